// File: rtl/alu_bist_pkg.sv
// Shared FSM encodings, polynomials and LFSR/MISR step helpers for the ALU self-test.
// Pure constants and functions; no timing, no backpressure.
package alu_bist_pkg;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [7:0]  LFSR_MASK = 8'hB8;
  localparam logic [15:0] MISR_POLY = 16'hB400;

  // Galois right-shift step used for both operand generators.
  function automatic logic [7:0] lfsr8_next(input logic [7:0] x);
    return (x >> 1) ^ (x[0] ? LFSR_MASK : 8'h00);
  endfunction

  function automatic logic [15:0] misr_next(input logic [15:0] m, input logic [15:0] d);
    return (m >> 1) ^ (m[0] ? MISR_POLY : 16'h0000) ^ d;
  endfunction

endpackage

// File: rtl/alu_bist_lfsr8.sv
// One 8-bit operand generator: seed load (zero seed forced to 8'h01) and step enable.
// Output is registered, updates one edge after load/step; no backpressure.
module lfsr8
  import alu_bist_pkg::*;
#(
  parameter logic [7:0] SEED = 8'h01
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       step,
  output logic [7:0] q
);

  // An all-zero state would lock the LFSR, so a zero seed is replaced.
  localparam logic [7:0] SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= 8'h00;
    end else if (load) begin
      q <= SEED_EFF;
    end else if (step) begin
      q <= lfsr8_next(q);
    end
  end

endmodule

// File: rtl/alu_bist.sv
// ALU BIST: sweeps all op codes with pseudo-random operands and compacts responses into a MISR.
// One vector per cycle, done NUM_OPS*VECTORS_PER_OP edges after start; start ignored while busy.
module alu_bist
  import alu_bist_pkg::*;
#(
  parameter int          WIDTH          = 8,
  parameter int          CTRL_W         = 4,
  parameter int          NUM_OPS        = 13,
  parameter int          VECTORS_PER_OP = 16,
  parameter logic [7:0]  SEED_A         = 8'hA5,
  parameter logic [7:0]  SEED_B         = 8'h3C,
  parameter logic [15:0] GOLDEN_SIG     = 16'h0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [WIDTH-1:0]  SrcA,
  output logic [WIDTH-1:0]  SrcB,
  output logic [CTRL_W-1:0] ALUControl,
  input  logic [WIDTH-1:0]  ALUResult,
  input  logic              Zero,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       signature
);

  localparam int VC_W = (VECTORS_PER_OP > 1) ? $clog2(VECTORS_PER_OP) : 1;
  localparam logic [VC_W-1:0]   VC_LAST = VC_W'(VECTORS_PER_OP - 1);
  localparam logic [CTRL_W-1:0] OP_LAST = CTRL_W'(NUM_OPS - 1);

  state_t            state;
  logic [VC_W-1:0]   vec_cnt;
  logic [CTRL_W-1:0] op_q;
  logic [15:0]       misr;
  logic [7:0]        a_q;
  logic [7:0]        b_q;

  logic run;
  logic launch;
  logic op_end;
  logic last_vec;
  logic step;

  assign run      = (state == ST_RUN);
  assign launch   = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign op_end   = (vec_cnt == VC_LAST);
  assign last_vec = op_end && (op_q == OP_LAST);
  // Operands freeze on the final vector so the DONE state shows what was last applied.
  assign step     = run && !last_vec;

  lfsr8 #(.SEED(SEED_A)) u_lfsr_a (
    .clk   (clk),
    .reset (reset),
    .load  (launch),
    .step  (step),
    .q     (a_q)
  );

  lfsr8 #(.SEED(SEED_B)) u_lfsr_b (
    .clk   (clk),
    .reset (reset),
    .load  (launch),
    .step  (step),
    .q     (b_q)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      vec_cnt <= '0;
      op_q    <= '0;
      misr    <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state   <= ST_RUN;
            vec_cnt <= '0;
            op_q    <= '0;
            misr    <= '0;
          end
        end
        ST_RUN: begin
          misr <= misr_next(misr, 16'({Zero, ALUResult}));
          if (last_vec) begin
            state <= ST_DONE;
          end else if (op_end) begin
            vec_cnt <= '0;
            op_q    <= op_q + CTRL_W'(1);
          end else begin
            vec_cnt <= vec_cnt + VC_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign SrcA       = WIDTH'(a_q);
  assign SrcB       = WIDTH'(b_q);
  assign ALUControl = op_q;
  assign busy       = run;
  assign done       = (state == ST_DONE);
  assign pass       = done && (misr == GOLDEN_SIG);
  assign signature  = misr;

endmodule

// File: tb/tb_alu_bist.sv
// Directed bench for alu_bist: reset, vector sequence, MISR unit, full sweep, fault and control corners.
module tb_alu_bist;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic start_f;
  logic start_s;

  int checks = 0;
  int errors = 0;

  // Behavioural 8-bit ALU with 13 op codes.
  function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    logic [7:0] r;
    case (op)
      4'd0:    r = a + b;
      4'd1:    r = a - b;
      4'd2:    r = a & b;
      4'd3:    r = a | b;
      4'd4:    r = a ^ b;
      4'd5:    r = {7'b0, ($signed(a) < $signed(b))};
      4'd6:    r = a << b[2:0];
      4'd7:    r = a >> b[2:0];
      4'd8:    r = 8'($signed(a) >>> b[2:0]);
      4'd9:    r = ~(a | b);
      4'd10:   r = {7'b0, (a < b)};
      4'd11:   r = b;
      4'd12:   r = ~a;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] lfsr_step(input logic [7:0] x);
    return {1'b0, x[7:1]} ^ (x[0] ? 8'hB8 : 8'h00);
  endfunction

  function automatic logic [7:0] lfsr_n(input logic [7:0] s, input int n);
    logic [7:0] x;
    x = s;
    for (int i = 0; i < n; i++) x = lfsr_step(x);
    return x;
  endfunction

  // Reference signature of a full default sweep; fault clears result bit 0 only.
  function automatic logic [15:0] model_sig(input logic fault);
    logic [7:0]  a;
    logic [7:0]  b;
    logic [7:0]  r;
    logic        z;
    logic [15:0] m;
    a = 8'hA5;
    b = 8'h3C;
    m = 16'h0000;
    for (int i = 0; i < 208; i++) begin
      r = alu_model(a, b, 4'(i / 16));
      z = (r == 8'h00);
      if (fault) r[0] = 1'b0;
      m = {1'b0, m[15:1]} ^ (m[0] ? 16'hB400 : 16'h0000) ^ {7'b0, z, r};
      a = lfsr_step(a);
      b = lfsr_step(b);
    end
    return m;
  endfunction

  localparam logic [15:0] GOLD  = model_sig(1'b0);
  localparam logic [15:0] FGOLD = model_sig(1'b1);
  localparam logic [7:0]  FIN_A = lfsr_n(8'hA5, 207);
  localparam logic [7:0]  FIN_B = lfsr_n(8'h3C, 207);

  // Full sweep instance with behavioural ALU.
  logic [7:0]  f_a, f_b, f_res;
  logic [3:0]  f_ctl;
  logic        f_zero, f_busy, f_done, f_pass;
  logic [15:0] f_sig;
  assign f_res  = alu_model(f_a, f_b, f_ctl);
  assign f_zero = (f_res == 8'h00);

  alu_bist #(.GOLDEN_SIG(GOLD)) u_full (
    .clk(clk), .reset(reset), .start(start_f),
    .SrcA(f_a), .SrcB(f_b), .ALUControl(f_ctl),
    .ALUResult(f_res), .Zero(f_zero),
    .busy(f_busy), .done(f_done), .pass(f_pass), .signature(f_sig)
  );

  // Same sweep with result bit 0 stuck low.
  logic [7:0]  x_a, x_b, x_raw, x_res;
  logic [3:0]  x_ctl;
  logic        x_zero, x_busy, x_done, x_pass;
  logic [15:0] x_sig;
  assign x_raw  = alu_model(x_a, x_b, x_ctl);
  assign x_res  = x_raw & 8'hFE;
  assign x_zero = (x_raw == 8'h00);

  alu_bist #(.GOLDEN_SIG(GOLD)) u_fault (
    .clk(clk), .reset(reset), .start(start_f),
    .SrcA(x_a), .SrcB(x_b), .ALUControl(x_ctl),
    .ALUResult(x_res), .Zero(x_zero),
    .busy(x_busy), .done(x_done), .pass(x_pass), .signature(x_sig)
  );

  // Two-vector sequence instance, ALU stub returns 0 with Zero=1.
  logic [7:0]  v_a, v_b;
  logic [3:0]  v_ctl;
  logic        v_busy, v_done, v_pass;
  logic [15:0] v_sig;

  alu_bist #(.NUM_OPS(1), .VECTORS_PER_OP(2)) u_vec (
    .clk(clk), .reset(reset), .start(start_s),
    .SrcA(v_a), .SrcB(v_b), .ALUControl(v_ctl),
    .ALUResult(8'h00), .Zero(1'b1),
    .busy(v_busy), .done(v_done), .pass(v_pass), .signature(v_sig)
  );

  // Single-vector MISR instance, ALU stub returns 8'h01 with Zero=0.
  logic [7:0]  m_a, m_b;
  logic [3:0]  m_ctl;
  logic        m_busy, m_done, m_pass;
  logic [15:0] m_sig;

  alu_bist #(.NUM_OPS(1), .VECTORS_PER_OP(1)) u_misr (
    .clk(clk), .reset(reset), .start(start_s),
    .SrcA(m_a), .SrcB(m_b), .ALUControl(m_ctl),
    .ALUResult(8'h01), .Zero(1'b0),
    .busy(m_busy), .done(m_done), .pass(m_pass), .signature(m_sig)
  );

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Observes u_full from just after the start edge until done, bounded.
  task automatic run_full(input int pulse_k, output int done_k, output int bcnt, output int cerr);
    done_k = -1;
    bcnt   = 0;
    cerr   = 0;
    for (int k = 0; k < 400; k++) begin
      if (f_done) begin
        done_k = k;
        break;
      end
      if (f_busy) begin
        bcnt++;
        if (f_ctl !== 4'(k / 16)) cerr++;
      end
      if (k == pulse_k) start_f = 1'b1;
      tick(1);
      start_f = 1'b0;
    end
  endtask

  int dk, bc, ce;

  initial begin
    reset   = 1'b1;
    start_f = 1'b0;
    start_s = 1'b0;
    tick(2);
    chk("reset_srca",  32'(f_a),    32'h0);
    chk("reset_srcb",  32'(f_b),    32'h0);
    chk("reset_ctl",   32'(f_ctl),  32'h0);
    chk("reset_busy",  32'(f_busy), 32'h0);
    chk("reset_done",  32'(f_done), 32'h0);
    chk("reset_pass",  32'(f_pass), 32'h0);
    chk("reset_sig",   32'(f_sig),  32'h0);
    reset = 1'b0;
    tick(1);

    // Short instances: edge 0
    start_s = 1'b1;
    tick(1);
    start_s = 1'b0;
    chk("vec0_srca", 32'(v_a),    32'hA5);
    chk("vec0_srcb", 32'(v_b),    32'h3C);
    chk("vec0_busy", 32'(v_busy), 32'h1);
    chk("vec0_ctl",  32'(v_ctl),  32'h0);
    chk("misr0_busy", 32'(m_busy), 32'h1);
    // edge 1
    tick(1);
    chk("vec1_srca", 32'(v_a),    32'hEA);
    chk("vec1_srcb", 32'(v_b),    32'h1E);
    chk("vec1_done", 32'(v_done), 32'h0);
    chk("misr_done", 32'(m_done), 32'h1);
    chk("misr_sig",  32'(m_sig),  32'h0001);
    chk("misr_pass", 32'(m_pass), 32'h0);
    chk("misr_busy", 32'(m_busy), 32'h0);
    chk("misr_srca_hold", 32'(m_a),   32'hA5);
    chk("misr_srcb_hold", 32'(m_b),   32'h3C);
    chk("misr_ctl",       32'(m_ctl), 32'h0);
    // edge 2
    tick(1);
    chk("vec2_done", 32'(v_done), 32'h1);
    chk("vec2_busy", 32'(v_busy), 32'h0);
    chk("vec2_srca_hold", 32'(v_a), 32'hEA);
    chk("vec2_sig",  32'(v_sig),  32'h0180);
    chk("vec2_pass", 32'(v_pass), 32'h0);

    // Full sweep, uninterrupted
    start_f = 1'b1;
    tick(1);
    start_f = 1'b0;
    run_full(-1, dk, bc, ce);
    chk("full_done_edge", 32'(dk),     32'd208);
    chk("full_busy_cyc",  32'(bc),     32'd208);
    chk("full_ctl_steps", 32'(ce),     32'd0);
    chk("full_pass",      32'(f_pass), 32'h1);
    chk("full_sig",       32'(f_sig),  32'(GOLD));
    chk("full_ctl_last",  32'(f_ctl),  32'd12);
    chk("full_srca_hold", 32'(f_a),    32'(FIN_A));
    chk("full_srcb_hold", 32'(f_b),    32'(FIN_B));
    chk("fault_done",     32'(x_done), 32'h1);
    chk("fault_busy",     32'(x_busy), 32'h0);
    chk("fault_pass",     32'(x_pass), 32'h0);
    chk("fault_sig_ne",   32'(x_sig !== GOLD), 32'h1);
    chk("fault_sig",      32'(x_sig),  32'(FGOLD));

    // Restart from DONE with a start pulse ignored mid-run
    start_f = 1'b1;
    tick(1);
    start_f = 1'b0;
    chk("restart_busy", 32'(f_busy), 32'h1);
    chk("restart_done", 32'(f_done), 32'h0);
    chk("restart_sig",  32'(f_sig),  32'h0);
    chk("restart_srca", 32'(f_a),    32'hA5);
    run_full(20, dk, bc, ce);
    chk("ign_done_edge", 32'(dk),     32'd208);
    chk("ign_busy_cyc",  32'(bc),     32'd208);
    chk("ign_sig",       32'(f_sig),  32'(GOLD));
    chk("ign_pass",      32'(f_pass), 32'h1);

    // Reset mid-run, then a clean run
    start_f = 1'b1;
    tick(1);
    start_f = 1'b0;
    tick(50);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("mreset_srca", 32'(f_a),    32'h0);
    chk("mreset_srcb", 32'(f_b),    32'h0);
    chk("mreset_ctl",  32'(f_ctl),  32'h0);
    chk("mreset_busy", 32'(f_busy), 32'h0);
    chk("mreset_done", 32'(f_done), 32'h0);
    chk("mreset_pass", 32'(f_pass), 32'h0);
    chk("mreset_sig",  32'(f_sig),  32'h0);
    start_f = 1'b1;
    tick(1);
    start_f = 1'b0;
    run_full(-1, dk, bc, ce);
    chk("rerun_done_edge", 32'(dk),     32'd208);
    chk("rerun_sig",       32'(f_sig),  32'(GOLD));
    chk("rerun_pass",      32'(f_pass), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
